// File: rtl/rg_pkg.sv
// rg_pkg: shared state encoding and frame geometry for the serial receiver
package rg_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, STOP = 2'd2} state_t;
   function automatic int frame_len(input int n);
      return n + 2;
   endfunction
endpackage

// File: rtl/serpar_rx_if.sv
// serpar_rx_if: serial line in, parallel word and status out
interface serpar_rx_if #(parameter int N = 4) ();
   logic         sin;
   logic         rd;
   logic [N-1:0] Q;
   logic         full;
   logic         vld;
   logic         ovr;
   logic         ferr;
   logic         busy;
   modport slave (input sin, rd, output Q, full, vld, ovr, ferr, busy);
   modport master (output sin, rd, input Q, full, vld, ovr, ferr, busy);
endinterface

// File: rtl/shiftpar_core.sv
// shiftpar_core: serial-in/parallel-out shift register, new bit enters at MSB
module shiftpar_core #(parameter int N = 4) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         en,
   input  logic         din,
   output logic [N-1:0] q
);
   // clear has priority so a fresh frame always starts from zero
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) q <= '0;
      else q <= clr ? '0 : en ? {din, q[N-1:1]} : q;
endmodule

// File: rtl/serpar_rx.sv
// serpar_rx: framed serial receiver with holding register and status flags
module serpar_rx import rg_pkg::*; #(parameter int N = 4) (
   input logic         clk,
   input logic         R,
   serpar_rx_if.slave  bus
);
   localparam int CW = $clog2(frame_len(N) - 1);
   state_t        state, state_nx;
   logic [CW-1:0] cnt;
   logic [N-1:0]  sr, q;
   logic          full, vld, ovr, ferr;
   logic          start, shift, good;
   assign start = state == IDLE && !bus.sin;
   assign shift = state == DATA;
   assign good  = state == STOP && bus.sin;
   shiftpar_core #(.N(N)) u_sr (
      .clk(clk), .rst_n(R), .clr(start), .en(shift), .din(bus.sin), .q(sr)
   );
   // next state: a stop bit always returns to IDLE, good or bad
   always_comb begin
      state_nx = IDLE;
      if (state == IDLE) state_nx = bus.sin ? IDLE : DATA;
      else if (state == DATA) state_nx = (cnt == CW'(N - 1)) ? STOP : DATA;
   end
   // state register and saturating data-bit counter
   always_ff @(posedge clk or negedge R)
      if (!R) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= start ? '0 : (shift && cnt != CW'(N)) ? cnt + 1'b1 : cnt;
      end
   // holding register and status; rd together with a good frame consumes the old word
   always_ff @(posedge clk or negedge R)
      if (!R) begin
         q    <= '0;
         full <= 1'b0;
         vld  <= 1'b0;
         ovr  <= 1'b0;
         ferr <= 1'b0;
      end else begin
         q    <= good ? sr : q;
         full <= good | (full & ~bus.rd);
         vld  <= good;
         ovr  <= ~bus.rd & (ovr | (good & full));
         ferr <= state == STOP && !bus.sin;
      end
   assign bus.Q    = q;
   assign bus.full = full;
   assign bus.vld  = vld;
   assign bus.ovr  = ovr;
   assign bus.ferr = ferr;
   assign bus.busy = state != IDLE;
endmodule

// File: tb/tb_serpar_rx.sv
// tb_serpar_rx: table-driven frames, corner sequences and randomized model check
module tb_serpar_rx;
   localparam int N = 4;
   logic clk = 1'b0;
   logic R = 1'b0;
   serpar_rx_if #(.N(N)) bus ();
   serpar_rx #(.N(N)) dut (.clk(clk), .R(R), .bus(bus));
   always #5 clk = ~clk;

   int checks = 0;
   int passed = 0;

   typedef struct {
      logic [N-1:0] d;
      logic         stop;
      logic         rd;
      logic [N-1:0] q;
      logic         full;
      logic         ovr;
      logic         vld;
      logic         ferr;
   } vec_t;
   vec_t tbl [7];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [N-1:0] d, input logic stop, input logic rd_stop);
      bus.sin = 1'b0;
      bus.rd  = 1'b0;
      tick();
      chk("vld_single_cycle", bus.vld, 0);
      chk("busy_in_frame", bus.busy, 1);
      for (int i = 0; i < N; i++) begin
         bus.sin = d[i];
         tick();
      end
      bus.sin = stop;
      bus.rd  = rd_stop;
      tick();
      bus.sin = 1'b1;
      bus.rd  = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      R = 1'b0;
      @(negedge clk);
      R = 1'b1;
   endtask

   // reference model: position within the frame and word built by arithmetic
   int           pos;
   int           word;
   logic [N-1:0] eq;
   logic         efull, eovr, evld, eferr;

   task automatic model_step(input logic s, input logic r);
      logic g;
      g = (pos == N) && s;
      evld  = g;
      eferr = (pos == N) && !s;
      if (g) begin
         eovr  = r ? 1'b0 : (eovr | efull);
         efull = 1'b1;
         eq    = N'(word);
      end else if (r) begin
         efull = 1'b0;
         eovr  = 1'b0;
      end
      if (pos == -1) begin
         if (!s) begin
            pos  = 0;
            word = 0;
         end
      end else if (pos < N) begin
         word = word + (int'(s) << pos);
         pos++;
      end else pos = -1;
   endtask

   initial begin
      bus.sin = 1'b1;
      bus.rd  = 1'b0;
      tbl = '{
         '{4'hD, 1'b1, 1'b0, 4'hD, 1'b1, 1'b0, 1'b1, 1'b0},
         '{4'hA, 1'b0, 1'b0, 4'hD, 1'b1, 1'b0, 1'b0, 1'b1},
         '{4'h3, 1'b1, 1'b0, 4'h3, 1'b1, 1'b1, 1'b1, 1'b0},
         '{4'hC, 1'b1, 1'b0, 4'hC, 1'b1, 1'b1, 1'b1, 1'b0},
         '{4'h9, 1'b1, 1'b1, 4'h9, 1'b1, 1'b0, 1'b1, 1'b0},
         '{4'h5, 1'b0, 1'b1, 4'h9, 1'b0, 1'b0, 1'b0, 1'b1},
         '{4'h0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0}
      };
      #12;
      chk("reset_q", bus.Q, 0);
      chk("reset_full", bus.full, 0);
      chk("reset_busy", bus.busy, 0);
      chk("reset_vld", bus.vld, 0);
      R = 1'b1;

      for (int i = 0; i < 7; i++) begin
         send(tbl[i].d, tbl[i].stop, tbl[i].rd);
         chk($sformatf("tbl%0d_q", i), bus.Q, tbl[i].q);
         chk($sformatf("tbl%0d_full", i), bus.full, tbl[i].full);
         chk($sformatf("tbl%0d_ovr", i), bus.ovr, tbl[i].ovr);
         chk($sformatf("tbl%0d_vld", i), bus.vld, tbl[i].vld);
         chk($sformatf("tbl%0d_ferr", i), bus.ferr, tbl[i].ferr);
         chk($sformatf("tbl%0d_busy", i), bus.busy, 0);
      end
      tick();
      chk("vld_falls", bus.vld, 0);

      // overrun, then a lone rd clears full and ovr
      send(4'h3, 1'b1, 1'b0);
      send(4'hC, 1'b1, 1'b0);
      chk("ovr_q", bus.Q, 4'hC);
      chk("ovr_set", bus.ovr, 1);
      bus.rd = 1'b1;
      tick();
      bus.rd = 1'b0;
      chk("rd_full_clr", bus.full, 0);
      chk("rd_ovr_clr", bus.ovr, 0);

      // reset in the middle of DATA discards the partial frame
      bus.sin = 1'b0;
      tick();
      bus.sin = 1'b1;
      tick();
      bus.sin = 1'b0;
      tick();
      #2 R = 1'b0;
      #1;
      chk("midreset_q", bus.Q, 0);
      chk("midreset_full", bus.full, 0);
      chk("midreset_busy", bus.busy, 0);
      @(negedge clk);
      bus.sin = 1'b1;
      R = 1'b1;
      send(4'hA, 1'b1, 1'b0);
      chk("after_reset_q", bus.Q, 4'hA);
      chk("after_reset_vld", bus.vld, 1);

      // zero-gap frames: each pulse is checked at its stop edge and cleared at the next start
      send(4'h1, 1'b1, 1'b0);
      chk("b2b_q1", bus.Q, 4'h1);
      chk("b2b_vld1", bus.vld, 1);
      send(4'hF, 1'b1, 1'b0);
      chk("b2b_q2", bus.Q, 4'hF);
      chk("b2b_vld2", bus.vld, 1);
      send(4'h7, 1'b1, 1'b0);
      chk("b2b_q3", bus.Q, 4'h7);
      chk("b2b_vld3", bus.vld, 1);

      // randomized line and acknowledge against the model
      do_reset();
      pos   = -1;
      word  = 0;
      eq    = '0;
      efull = 1'b0;
      eovr  = 1'b0;
      evld  = 1'b0;
      eferr = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         logic s, r;
         s = $urandom_range(0, 2) != 0;
         r = $urandom_range(0, 7) == 0;
         bus.sin = s;
         bus.rd  = r;
         tick();
         model_step(s, r);
         chk("rnd_q", bus.Q, eq);
         chk("rnd_full", bus.full, efull);
         chk("rnd_ovr", bus.ovr, eovr);
         chk("rnd_vld", bus.vld, evld);
         chk("rnd_ferr", bus.ferr, eferr);
         chk("rnd_busy", bus.busy, pos != -1);
      end
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
